// File: rtl/normalizer_pkg.sv
// Shared definitions for the pipelined normaliser.
// Holds the default widths, the packed flag struct and the flag bit positions.
package normalizer_pkg;

   localparam int DEFAULT_MANTISSA_N = 25;
   localparam int DEFAULT_EXP_N      = 8;

   // out_flags bit positions, matching the field order of norm_flags_t
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_ZERO      = 0;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic zero;
   } norm_flags_t;

endpackage

// File: rtl/pipelined_normalizer_if.sv
// Valid/ready stream interface of the normaliser.
// The in_* channel carries raw mantissa/exponent into the block.
// The out_* channel carries the normalised result, sticky bit and flags.
// Modports:
//   master - the environment side (drives in_* data, in_valid and out_ready)
//   slave  - the normaliser side
interface pipelined_normalizer_if
   import normalizer_pkg::*;
#(
   parameter int MANTISSA_N = DEFAULT_MANTISSA_N,
   parameter int EXP_N      = DEFAULT_EXP_N
);

   logic                  in_valid;
   logic                  in_ready;
   logic [MANTISSA_N-1:0] in_mantissa;
   logic [EXP_N-1:0]      in_exp;

   logic                  out_valid;
   logic                  out_ready;
   logic [MANTISSA_N-1:0] out_mantissa;
   logic [EXP_N-1:0]      out_exp;
   logic                  out_sticky;
   logic [2:0]            out_flags;

   modport master (
      output in_valid, in_mantissa, in_exp, out_ready,
      input  in_ready, out_valid, out_mantissa, out_exp, out_sticky, out_flags
   );

   modport slave (
      input  in_valid, in_mantissa, in_exp, out_ready,
      output in_ready, out_valid, out_mantissa, out_exp, out_sticky, out_flags
   );

endinterface

// File: rtl/leading_zero_counter.sv
// Leading-zero counter.
// Ports:
//   data     - word to scan, MSB first
//   count    - number of zeros above the highest set bit (WIDTH when all zero)
//   all_zero - data is entirely zero
module leading_zero_counter #(
   parameter int WIDTH = 24,
   parameter int CNT_N = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] data,
   output logic [CNT_N-1:0] count,
   output logic             all_zero
);

   // Scanning upward lets the highest set bit make the final assignment.
   always_comb begin
      count = CNT_N'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data[i]) count = CNT_N'(WIDTH - 1 - i);
      end
   end

   assign all_zero = (data == '0);

endmodule

// File: rtl/pipelined_normalizer.sv
// Two-stage mantissa normaliser with valid/ready flow control.
// S1 captures the input, its carry bit and leading-zero count; S2 applies the
// shift, adjusts the exponent and produces sticky and flags.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - normaliser stream interface (slave side)
module pipelined_normalizer
   import normalizer_pkg::*;
#(
   parameter int MANTISSA_N = DEFAULT_MANTISSA_N,
   parameter int EXP_N      = DEFAULT_EXP_N
) (
   input logic                 clk,
   input logic                 rst_n,
   pipelined_normalizer_if.slave bus
);

   localparam int SHIFT_N = $clog2(MANTISSA_N);
   localparam int FRAC_N  = MANTISSA_N - 1;
   localparam logic [EXP_N-1:0] EXP_MAX   = '1;
   localparam logic [EXP_N:0]   EXP_MAX_W = {1'b0, EXP_MAX};

   logic                  s1_valid;
   logic [MANTISSA_N-1:0] s1_mant;
   logic [EXP_N-1:0]      s1_exp;
   logic                  s1_carry;
   logic                  s1_zero;
   logic [SHIFT_N-1:0]    s1_lz;

   logic                  s2_ready;
   logic [SHIFT_N-1:0]    lz_cnt;
   logic                  lz_all_zero;

   logic [MANTISSA_N-1:0] out_mant_q;
   logic [EXP_N-1:0]      out_exp_q;
   logic                  out_sticky_q;
   logic                  out_valid_q;
   norm_flags_t           out_flags_q;

   logic [MANTISSA_N-1:0] nx_mant;
   logic [EXP_N-1:0]      nx_exp;
   logic                  nx_sticky;
   norm_flags_t           nx_flags;
   logic [SHIFT_N-1:0]    shamt;
   logic [EXP_N:0]        e_inc;
   logic [EXP_N:0]        e_dec;
   logic [EXP_N:0]        lz_w;

   assign s2_ready     = !out_valid_q || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_ready;

   leading_zero_counter #(
      .WIDTH (FRAC_N),
      .CNT_N (SHIFT_N)
   ) u_lzc (
      .data     (bus.in_mantissa[FRAC_N-1:0]),
      .count    (lz_cnt),
      .all_zero (lz_all_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_mant  <= '0;
         s1_exp   <= '0;
         s1_carry <= 1'b0;
         s1_zero  <= 1'b0;
         s1_lz    <= '0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mant  <= bus.in_mantissa;
            s1_exp   <= bus.in_exp;
            s1_carry <= bus.in_mantissa[MANTISSA_N-1];
            s1_zero  <= lz_all_zero && !bus.in_mantissa[MANTISSA_N-1];
            s1_lz    <= lz_cnt;
         end
      end
   end

   // Exponent math is one bit wider than EXP_N so neither +1 nor -lz wraps.
   assign e_inc = {1'b0, s1_exp} + (EXP_N+1)'(1);
   assign lz_w  = (EXP_N+1)'(s1_lz);
   assign e_dec = {1'b0, s1_exp} - lz_w;

   always_comb begin
      nx_mant   = s1_mant;
      nx_exp    = s1_exp;
      nx_sticky = 1'b0;
      nx_flags  = '0;
      shamt     = '0;
      if (s1_exp == EXP_MAX) begin
         // inf/NaN: pass through untouched
      end else if (s1_zero) begin
         nx_mant       = '0;
         nx_exp        = '0;
         nx_flags.zero = 1'b1;
      end else if (s1_carry) begin
         if (e_inc >= EXP_MAX_W) begin
            nx_mant           = '0;
            nx_exp            = EXP_MAX;
            nx_flags.overflow = 1'b1;
         end else begin
            nx_mant   = s1_mant >> 1;
            nx_exp    = e_inc[EXP_N-1:0];
            nx_sticky = s1_mant[0];
         end
      end else if (lz_w >= {1'b0, s1_exp}) begin
         // Here s1_exp <= s1_lz <= MANTISSA_N-2, so it fits the shift width.
         shamt              = s1_exp[SHIFT_N-1:0];
         nx_mant            = s1_mant << shamt;
         nx_exp             = '0;
         nx_flags.underflow = 1'b1;
      end else begin
         shamt   = s1_lz;
         nx_mant = s1_mant << shamt;
         nx_exp  = e_dec[EXP_N-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_mant_q   <= '0;
         out_exp_q    <= '0;
         out_sticky_q <= 1'b0;
         out_flags_q  <= '0;
      end else if (s2_ready) begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            out_mant_q   <= nx_mant;
            out_exp_q    <= nx_exp;
            out_sticky_q <= nx_sticky;
            out_flags_q  <= nx_flags;
         end
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_mantissa = out_mant_q;
   assign bus.out_exp      = out_exp_q;
   assign bus.out_sticky   = out_sticky_q;
   assign bus.out_flags    = out_flags_q;

endmodule

// File: tb/tb_pipelined_normalizer.sv
// Directed self-checking bench for pipelined_normalizer (MANTISSA_N=25, EXP_N=8).
module tb_pipelined_normalizer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   pipelined_normalizer_if #(.MANTISSA_N(25), .EXP_N(8)) nif ();

   pipelined_normalizer #(.MANTISSA_N(25), .EXP_N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (nif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Presents one item with out_ready high and checks the 2-cycle result.
   task automatic run_vec(input string tag, input logic [24:0] m, input logic [7:0] e,
                          input logic [24:0] xm, input logic [7:0] xe,
                          input logic xs, input logic [2:0] xf);
      @(negedge clk);
      nif.in_valid    = 1'b1;
      nif.in_mantissa = m;
      nif.in_exp      = e;
      @(negedge clk);
      nif.in_valid = 1'b0;
      check({tag, "_early"}, {31'd0, nif.out_valid}, 32'd0);
      @(negedge clk);
      check({tag, "_valid"}, {31'd0, nif.out_valid}, 32'd1);
      check({tag, "_mant"},  {7'd0, nif.out_mantissa}, {7'd0, xm});
      check({tag, "_exp"},   {24'd0, nif.out_exp}, {24'd0, xe});
      check({tag, "_stk"},   {31'd0, nif.out_sticky}, {31'd0, xs});
      check({tag, "_flags"}, {29'd0, nif.out_flags}, {29'd0, xf});
   endtask

   logic [24:0] bp_m [5];
   logic [7:0]  bp_e [5];

   initial begin
      n_checks        = 0;
      n_pass          = 0;
      rst_n           = 1'b0;
      nif.in_valid    = 1'b0;
      nif.in_mantissa = '0;
      nif.in_exp      = '0;
      nif.out_ready   = 1'b1;

      #12;
      check("rst_out_valid", {31'd0, nif.out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, nif.in_ready}, 32'd1);
      check("rst_mant",      {7'd0, nif.out_mantissa}, 32'd0);
      check("rst_exp",       {24'd0, nif.out_exp}, 32'd0);
      check("rst_flags",     {29'd0, nif.out_flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_vec("carry",   25'h1000001, 8'd10,  25'h0800000, 8'd11,  1'b1, 3'b000);
      run_vec("lshift",  25'h0000400, 8'd100, 25'h0800000, 8'd87,  1'b0, 3'b000);
      run_vec("uflow",   25'h0000400, 8'd5,   25'h0008000, 8'd0,   1'b0, 3'b010);
      run_vec("zero",    25'h0000000, 8'd40,  25'h0000000, 8'd0,   1'b0, 3'b001);
      run_vec("oflow",   25'h1000000, 8'hFE,  25'h0000000, 8'hFF,  1'b0, 3'b100);
      run_vec("pass",    25'h0000400, 8'hFF,  25'h0000400, 8'hFF,  1'b0, 3'b000);
      run_vec("uf_edge", 25'h0000400, 8'd13,  25'h0800000, 8'd0,   1'b0, 3'b010);
      run_vec("norm",    25'h0800000, 8'd50,  25'h0800000, 8'd50,  1'b0, 3'b000);
      run_vec("carry_hi",25'h1000002, 8'hFD,  25'h0800001, 8'hFE,  1'b0, 3'b000);
      run_vec("lz_max",  25'h0000001, 8'd30,  25'h0800000, 8'd7,   1'b0, 3'b000);

      // Backpressure: already-normalised items come out unchanged.
      for (int k = 0; k < 5; k++) begin
         bp_m[k] = 25'h0800000 | 25'(k * 3 + 1);
         bp_e[k] = 8'(20 + k);
      end
      @(negedge clk);
      fork
         begin : producer
            for (int k = 0; k < 5; k++) begin
               logic rdy;
               int   guard;
               nif.in_valid    = 1'b1;
               nif.in_mantissa = bp_m[k];
               nif.in_exp      = bp_e[k];
               guard = 0;
               do begin
                  rdy = nif.in_ready;
                  @(posedge clk);
                  @(negedge clk);
                  guard++;
               end while (!rdy && guard < 20);
               if (!rdy) check("bp_timeout", 32'd0, 32'd1);
            end
            nif.in_valid = 1'b0;
         end
         begin : consumer
            int          idx;
            logic        saw_stall;
            logic        have_prev;
            logic [24:0] pm;
            logic [7:0]  pe;
            idx       = 0;
            saw_stall = 1'b0;
            have_prev = 1'b0;
            pm        = '0;
            pe        = '0;
            for (int c = 0; c < 30; c++) begin
               @(posedge clk);
               #1;
               nif.out_ready = !(c < 3);
               @(negedge clk);
               if (!nif.in_ready) saw_stall = 1'b1;
               if (have_prev) begin
                  check("bp_hold_mant", {7'd0, nif.out_mantissa}, {7'd0, pm});
                  check("bp_hold_exp",  {24'd0, nif.out_exp}, {24'd0, pe});
               end
               have_prev = nif.out_valid && !nif.out_ready;
               pm = nif.out_mantissa;
               pe = nif.out_exp;
               if (nif.out_valid && nif.out_ready) begin
                  if (idx < 5) begin
                     check("bp_mant", {7'd0, nif.out_mantissa}, {7'd0, bp_m[idx]});
                     check("bp_exp",  {24'd0, nif.out_exp}, {24'd0, bp_e[idx]});
                  end
                  idx++;
               end
            end
            check("bp_count", idx, 32'd5);
            check("bp_stall_seen", {31'd0, saw_stall}, 32'd1);
         end
      join
      nif.out_ready = 1'b1;

      // Reset with two items in flight.
      @(negedge clk);
      nif.in_valid    = 1'b1;
      nif.in_mantissa = 25'h0000400;
      nif.in_exp      = 8'd100;
      @(negedge clk);
      nif.in_mantissa = 25'h1000001;
      nif.in_exp      = 8'd10;
      @(negedge clk);
      nif.in_valid = 1'b0;
      check("mid_pre_valid", {31'd0, nif.out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, nif.out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, nif.in_ready}, 32'd1);
      check("mid_rst_mant",  {7'd0, nif.out_mantissa}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         logic stale;
         stale = 1'b0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (nif.out_valid) stale = 1'b1;
         end
         check("mid_no_stale", {31'd0, stale}, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipelined_normalizer.md
PIPELINED_NORMALIZER -- requirements
Module: pipelined_normalizer

Interface
REQ-001 SHALL have parameter MANTISSA_N, default 25: mantissa width; bit MANTISSA_N-1 is the carry bit; bit MANTISSA_N-2 is the hidden-bit position.
REQ-002 SHALL have parameter EXP_N, default 8: unsigned biased exponent width.
REQ-003 SHALL have localparam SHIFT_N = $clog2(MANTISSA_N): shift-count width.
REQ-004 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: in_mantissa/in_exp are valid.
REQ-007 Port in_ready, output, 1: block accepts input this cycle.
REQ-008 Port in_mantissa, input, MANTISSA_N: raw sum mantissa.
REQ-009 Port in_exp, input, EXP_N: exponent before normalisation.
REQ-010 Port out_valid, output, 1: output fields are valid.
REQ-011 Port out_ready, input, 1: downstream accepts output.
REQ-012 Port out_mantissa, output, MANTISSA_N: normalised mantissa.
REQ-013 Port out_exp, output, EXP_N: adjusted exponent.
REQ-014 Port out_sticky, output, 1: bit lost on the right shift.
REQ-015 Port out_flags, output, 3: {overflow, underflow, zero}.

Function
REQ-016 SHALL be a 2-stage pipeline. S1 registers the input, the carry bit, and the leading-zero count; S2 registers the shifted mantissa, the exponent, and the flags. Latency is exactly 2 cycles with no stall.
REQ-017 Each stage SHALL have a valid bit. A stage loads when its downstream stage is empty or is being drained that cycle: in_ready = !s1_valid || s2_ready; s2_ready = !out_valid || out_ready.
REQ-018 A transfer SHALL occur only when valid && ready. Full throughput is one item per cycle, with no bubbles when out_ready stays high.
REQ-019 While out_valid=1 && out_ready=0, all out_* signals SHALL hold stable.
REQ-020 Carry set (in_mantissa[MSB]=1) SHALL produce:
- mantissa >> 1
- exp + 1
- sticky = in_mantissa[0]
REQ-021 Carry clear and mantissa nonzero SHALL produce:
- lz = count of leading zeros below the carry bit
- left shift by lz, exp - lz
- sticky = 0
REQ-022 Underflow: if lz >= in_exp, the block SHALL shift by in_exp only, set out_exp=0, and set underflow=1 (denormal result).
REQ-023 Overflow: if the carry path gives exp+1 = all-ones, the block SHALL output exp = all-ones, mantissa = 0 and overflow=1 (infinity).
REQ-024 Zero mantissa SHALL output mantissa=0, exp=0, zero=1, sticky=0, with other flags 0.
REQ-025 An input with in_exp = all-ones SHALL pass through unchanged with no flags set (inf/NaN passthrough).
REQ-026 Exponent arithmetic SHALL be computed at EXP_N+1 bits so no wrap-around occurs; results are clamped per REQ-022/023.
REQ-027 The shift amount SHALL never exceed MANTISSA_N-2.

Reset
REQ-028 rst_n low SHALL asynchronously clear s1_valid, out_valid, and all data and flag registers to 0.
REQ-029 During reset in_ready SHALL be 1. The first input SHALL be accepted on the first edge after rst_n deasserts.
REQ-030 A reset asserted mid-operation SHALL discard all in-flight items; no output is produced for them.

Structure
REQ-031 Package normalizer_pkg SHALL hold the default MANTISSA_N/EXP_N constants, the packed flags struct {overflow, underflow, zero}, and the flag bit-index constants.
REQ-032 The leading-zero count SHALL be implemented in sub-module leading_zero_counter, parametrised on width, producing the count and an all-zero indication.
REQ-033 The left shift SHALL be performed in S2 from registered S1 values only.

Verification (MANTISSA_N=25, EXP_N=8)
REQ-034 Carry case:
- stimulus: in 25'h1000001, exp 8'd10
- response: out 25'h0800000, exp 8'd11, sticky 1, flags 0, exactly 2 cycles later.
REQ-035 Left-shift case:
- stimulus: in 25'h0000400, exp 8'd100
- response: out 25'h0800000, exp 8'd87, flags 0.
REQ-036 Underflow and zero cases:
- in 25'h0000400, exp 8'd5 -> out 25'h0008000, exp 0, underflow=1.
- in 0, exp 8'd40 -> out 0, exp 0, zero=1.
REQ-037 Overflow case:
- stimulus: in 25'h1000000, exp 8'hFE
- response: out 0, exp 8'hFF, overflow=1.
REQ-038 Backpressure:
- stimulus: stream 5 back-to-back items; hold out_ready=0 for 3 cycles.
- response: in_ready drops once both stages are full; outputs stay stable while stalled; all 5 items emerge in order with no loss or duplication.
REQ-039 Reset mid-operation:
- stimulus: pulse rst_n low while 2 items are in flight.
- response: out_valid=0 immediately (asynchronous); no stale output appears after release.
